delay_pulse_gen_multi: RTL
==========================

// Module: delay_pulse_gen_multi
// PURPOSE
//  Multi-channel programmable delay/pulse generator for sequencing, power-up and enable timing.
//  Per channel: after a start event, wait DELAY cycles, then drive a LEVEL (latched), single PULSE or PERIODIC pulse train.
//  Channels with AUTO_START behave as fixed power-up delays: output asserts DEF_DELAY edges after reset release.
// PARAMETERS
//  NCH        4    number of independent channels
//  CW         30   counter / delay / width field width (bits)
//  DEF_DELAY  10   reset value of every channel's delay register
//  DEF_WIDTH  1    reset value of every channel's width register
//  DEF_MODE   0    reset value of every channel's mode register (0=LEVEL)
//  AUTO_START {NCH{1'b1}}  per-channel mask: channel self-starts on reset release
//  ACTIVE_LOW 1    1: asserted output = 0, idle output = 1; 0: inverted
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       reset, synchronous, active-low
//  start      in   NCH     per-channel start request, sampled each edge
//  abort      in   NCH     per-channel abort: return to IDLE, deassert output
//  cfg_we     in   1       config write strobe
//  cfg_ch     in   clog2(NCH)  channel index for write (out-of-range: write ignored)
//  cfg_mode   in   2       0=LEVEL 1=PULSE 2=PERIODIC 3=reserved (acts as PULSE)
//  cfg_delay  in   CW      delay in cycles (0 treated as 1)
//  cfg_width  in   CW      pulse width in cycles (0 treated as 1)
//  out        out  NCH     delayed outputs, polarity per ACTIVE_LOW
//  busy       out  NCH     1 when channel not in IDLE
//  done       out  NCH     1-cycle strobe, see BEHAVIOUR
// BEHAVIOUR
//  Reset (rst=0 at edge): cfg regs <- DEF_*; out = inactive; done=0; AUTO_START channels -> DELAY with
//   cnt=max(DEF_DELAY,1)-1 and shadow=DEF_*; all other channels -> IDLE with busy=0.
//  Per-channel FSM (states IDLE, DELAY, ACTIVE, HOLD), down-counter cnt[CW-1:0]:
//   IDLE:   start=1 -> latch mode/delay/width into shadow, cnt<=D-1, -> DELAY.
//   DELAY:  cnt==0 -> assert out, cnt<=W-1, -> ACTIVE (LEVEL: -> HOLD, done=1); else cnt--.
//   ACTIVE: cnt==0 -> deassert out, done=1; PULSE -> IDLE; PERIODIC -> cnt<=D-1, DELAY; else cnt--.
//   HOLD:   out stays asserted until abort or rst.
//  Timing: start sampled at edge E0 -> out asserted after edge E0+D, deasserted after E0+D+W;
//   PERIODIC period = D+W. AUTO_START: E0 = last edge with rst=0 (out asserts after the D-th edge with rst=1).
//  Config is double-buffered: cfg writes update only cfg regs; a running channel uses its
//   shadow copy until next start. Write and start to same channel on same edge: start uses OLD cfg.
//  start while busy: ignored (no retrigger). abort: any state -> IDLE, out inactive next edge,
//   no done. abort+start same edge: abort wins, channel IDLE.
//  rst mid-operation: immediate return to reset state at that edge, pending done suppressed.
//  done, out, busy are registered outputs; no combinational path from inputs.
//  Counter never wraps: decrement only when cnt!=0; D, W clamped to >=1 at latch time.
// STRUCTURE
//  Package delay_pulse_pkg: mode encodings (MODE_LEVEL/PULSE/PERIODIC), state encodings.
//  Sub-module delay_pulse_chan: one channel FSM + counter + shadow regs; top holds cfg regs,
//   write decode and a generate loop of NCH delay_pulse_chan instances.
// TESTING
//  Reset release, defaults (D=10, LEVEL, AUTO_START all) -> out[i]=1 for 9 edges, 0 after 10th, done pulses once.
//  cfg ch1 PULSE D=3 W=2, start[1] at E0 -> out[1] low after E3..E4, high after E5, done[1] at E5, busy clears.
//  ch2 PERIODIC D=2 W=1 -> out[2] low 1 cycle every 3 cycles; abort mid-pulse -> out high next edge, no done.
//  cfg_delay=0/cfg_width=0 -> behaves as D=1/W=1; start during busy ignored; abort+start same edge -> IDLE.
//  cfg write to running ch3 (D 5->20) -> current run keeps 5; next start uses 20.
//  rst low mid-DELAY and mid-HOLD -> outputs inactive at that edge, counters reloaded to DEF_DELAY-1.

Source files
------------

// File: rtl/delay_pulse_pkg.sv
// Shared encodings for the multi-channel delay/pulse generator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// mode_e  : output behaviour once a channel's delay has elapsed.
// state_e : per-channel sequencing state.
package delay_pulse_pkg;

   // RSVD is decoded exactly like PULSE by the channel FSM.
   typedef enum logic [1:0] {
      MODE_LEVEL    = 2'd0,
      MODE_PULSE    = 2'd1,
      MODE_PERIODIC = 2'd2,
      MODE_RSVD     = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;

endpackage

// File: rtl/delay_pulse_chan.sv
// One delay/pulse channel: FSM, down-counter and shadow copy of mode/delay/width.
// Latency: start sampled at edge E0 -> act high after E0+D, low after E0+D+W; all outputs registered.
// Backpressure: none; start while busy is dropped, abort forces IDLE on the next edge.
//
// Ports: clk/rst (sync, active-low); start/abort per-channel requests;
//        cfg_mode/cfg_delay/cfg_width = committed config, copied into shadow on start;
//        act = output asserted (polarity applied by parent); busy = not IDLE; done = 1-cycle strobe.
module delay_pulse_chan
   import delay_pulse_pkg::*;
#(
   parameter int unsigned CW         = 30,
   parameter int unsigned DEF_DELAY  = 10,
   parameter int unsigned DEF_WIDTH  = 1,
   parameter logic [1:0]  DEF_MODE   = 2'd0,
   parameter bit          AUTO_START = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [1:0]    cfg_mode,
   input  logic [CW-1:0] cfg_delay,
   input  logic [CW-1:0] cfg_width,
   output logic          act,
   output logic          busy,
   output logic          done
);

   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW-1:0] DEF_D = (DEF_DELAY == 0) ? ONE : CW'(DEF_DELAY);
   localparam logic [CW-1:0] DEF_W = (DEF_WIDTH == 0) ? ONE : CW'(DEF_WIDTH);

   // Zero-length delay/width would make the counter wrap; treat as one cycle.
   function automatic logic [CW-1:0] clamp1(input logic [CW-1:0] v);
      return (v == '0) ? ONE : v;
   endfunction

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   mode_e         mode_q,  mode_d;
   logic [CW-1:0] dly_q,   dly_d;
   logic [CW-1:0] wid_q,   wid_d;
   logic          done_q,  done_d;

   // State register. Reset lands AUTO_START channels directly in DELAY so the
   // reset edge itself acts as the start edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= AUTO_START ? ST_DELAY : ST_IDLE;
         cnt_q   <= AUTO_START ? (DEF_D - ONE) : '0;
         mode_q  <= mode_e'(DEF_MODE);
         dly_q   <= DEF_D;
         wid_q   <= DEF_W;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         dly_q   <= dly_d;
         wid_q   <= wid_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic. abort outranks everything, including a same-edge start.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      dly_d   = dly_q;
      wid_d   = wid_q;
      done_d  = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mode_d  = mode_e'(cfg_mode);
                  dly_d   = clamp1(cfg_delay);
                  wid_d   = clamp1(cfg_width);
                  cnt_d   = clamp1(cfg_delay) - ONE;
                  state_d = ST_DELAY;
               end
            end
            ST_DELAY: begin
               if (cnt_q == '0) begin
                  if (mode_q == MODE_LEVEL) begin
                     state_d = ST_HOLD;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_ACTIVE;
                     cnt_d   = wid_q - ONE;
                  end
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            ST_ACTIVE: begin
               if (cnt_q == '0) begin
                  done_d = 1'b1;
                  if (mode_q == MODE_PERIODIC) begin
                     state_d = ST_DELAY;
                     cnt_d   = dly_q - ONE;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            ST_HOLD: begin
               state_d = ST_HOLD;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decode registered state only.
   always_comb begin
      act  = (state_q == ST_ACTIVE) || (state_q == ST_HOLD);
      busy = (state_q != ST_IDLE);
      done = done_q;
   end

endmodule

// File: rtl/delay_pulse_gen_multi.sv
// Multi-channel programmable delay / pulse / periodic generator with double-buffered config.
// Latency: cfg write visible to a channel's next start; outputs registered, E0+D assert, E0+D+W release.
// Backpressure: none; starts to busy channels are dropped, out-of-range cfg_ch writes are ignored.
//
// Ports: clk, rst (sync, active-low); start/abort[NCH] per-channel requests;
//        cfg_we/cfg_ch/cfg_mode/cfg_delay/cfg_width config write port;
//        out[NCH] (ACTIVE_LOW polarity), busy[NCH], done[NCH] 1-cycle strobes.
module delay_pulse_gen_multi
   import delay_pulse_pkg::*;
#(
   parameter int unsigned   NCH        = 4,
   parameter int unsigned   CW         = 30,
   parameter int unsigned   DEF_DELAY  = 10,
   parameter int unsigned   DEF_WIDTH  = 1,
   parameter logic [1:0]    DEF_MODE   = 2'd0,
   parameter logic [NCH-1:0] AUTO_START = {NCH{1'b1}},
   parameter bit            ACTIVE_LOW = 1'b1,
   localparam int unsigned  CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] start,
   input  logic [NCH-1:0] abort,
   input  logic           cfg_we,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [1:0]     cfg_mode,
   input  logic [CW-1:0]  cfg_delay,
   input  logic [CW-1:0]  cfg_width,
   output logic [NCH-1:0] out,
   output logic [NCH-1:0] busy,
   output logic [NCH-1:0] done
);

   logic [1:0]    cfg_mode_q  [NCH];
   logic [1:0]    cfg_mode_d  [NCH];
   logic [CW-1:0] cfg_delay_q [NCH];
   logic [CW-1:0] cfg_delay_d [NCH];
   logic [CW-1:0] cfg_width_q [NCH];
   logic [CW-1:0] cfg_width_d [NCH];
   logic [NCH-1:0] act;
   logic [31:0]    cfg_ch_ext;

   assign cfg_ch_ext = 32'(cfg_ch);

   // Write decode by equality against every channel index, so an index with
   // no matching channel simply writes nothing.
   always_comb begin
      cfg_mode_d  = cfg_mode_q;
      cfg_delay_d = cfg_delay_q;
      cfg_width_d = cfg_width_q;
      for (int i = 0; i < NCH; i++) begin
         if (cfg_we && (cfg_ch_ext == 32'(i))) begin
            cfg_mode_d[i]  = cfg_mode;
            cfg_delay_d[i] = cfg_delay;
            cfg_width_d[i] = cfg_width;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            cfg_mode_q[i]  <= DEF_MODE;
            cfg_delay_q[i] <= CW'(DEF_DELAY);
            cfg_width_q[i] <= CW'(DEF_WIDTH);
         end
      end else begin
         cfg_mode_q  <= cfg_mode_d;
         cfg_delay_q <= cfg_delay_d;
         cfg_width_q <= cfg_width_d;
      end
   end

   // Channels see the committed cfg registers, so a write and a start on the
   // same edge start with the previous configuration.
   for (genvar g = 0; g < NCH; g++) begin : g_chan
      delay_pulse_chan #(
         .CW         (CW),
         .DEF_DELAY  (DEF_DELAY),
         .DEF_WIDTH  (DEF_WIDTH),
         .DEF_MODE   (DEF_MODE),
         .AUTO_START (AUTO_START[g])
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .start     (start[g]),
         .abort     (abort[g]),
         .cfg_mode  (cfg_mode_q[g]),
         .cfg_delay (cfg_delay_q[g]),
         .cfg_width (cfg_width_q[g]),
         .act       (act[g]),
         .busy      (busy[g]),
         .done      (done[g])
      );
      assign out[g] = act[g] ^ ACTIVE_LOW;
   end

endmodule
